// File: rtl/word_transmitter.sv
// Buffers 32-bit words in a FIFO and sends each one MSB byte first over an 8N1 UART line.
// Define WORD_TRANSMITTER_END_MARKER_EN to send a 0xFFFFFFFF terminator after a finish pulse.
module word_transmitter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        finish,
    output logic        UART_TX,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] TMAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_d;
    logic ready_q, tx_q, busy_q;
    logic push, pop, fifo_ne;

    state_t state, state_d;
    logic [15:0] timer, timer_d;
    logic [2:0] bit_idx, bit_idx_d;
    logic [1:0] byte_idx, byte_idx_d;
    logic [31:0] shreg, shreg_d;
    logic [7:0] cur_byte;
    logic tick, load, last_tick, have_word;
    logic term_req, hold_ready, busy_hold;

`ifdef WORD_TRANSMITTER_END_MARKER_EN
    logic pend, term_act;

    assign term_req   = pend && !term_act;
    assign hold_ready = pend || finish;
    assign busy_hold  = pend;

    // term_act marks that the word in the shifter is the terminator
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pend     <= 1'b0;
            term_act <= 1'b0;
        end else begin
            if (load)
                term_act <= !fifo_ne;
            else if (last_tick)
                term_act <= 1'b0;
            if (!pend && finish)
                pend <= 1'b1;
            else if (term_act && last_tick)
                pend <= 1'b0;
        end
    end
`else
    logic unused_finish;

    assign unused_finish = finish;
    assign term_req      = 1'b0;
    assign hold_ready    = 1'b0;
    assign busy_hold     = 1'b0;
`endif

    assign fifo_ne    = (count != '0);
    assign push       = word_valid && ready_q;
    assign pop        = load && fifo_ne;
    assign tick       = (timer == TMAX);
    assign last_tick  = (state == STOP) && tick && (byte_idx == 2'd3);
    assign have_word  = fifo_ne || term_req;
    assign cur_byte   = shreg[31:24];
    assign word_ready = ready_q;
    assign UART_TX    = tx_q;
    assign busy       = busy_q;

    always_comb begin
        count_d = count;
        if (push && !pop)
            count_d = count + CNT_ONE;
        else if (pop && !push)
            count_d = count - CNT_ONE;
    end

    always_comb begin
        state_d    = state;
        timer_d    = timer + 16'd1;
        bit_idx_d  = bit_idx;
        byte_idx_d = byte_idx;
        shreg_d    = shreg;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                timer_d = '0;
                if (have_word) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d   = '0;
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    timer_d = '0;
                    if (byte_idx != 2'd3) begin
                        state_d    = START;
                        byte_idx_d = byte_idx + 2'd1;
                        shreg_d    = {shreg[23:0], 8'h00};
                    end else if (have_word) begin
                        state_d = START;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            byte_idx_d = '0;
            shreg_d    = fifo_ne ? mem[rd_ptr] : 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= word_in;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_d;
        end
    end

    // line and busy lag the state by one cycle so both share the frame timeline
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            bit_idx  <= bit_idx_d;
            byte_idx <= byte_idx_d;
            shreg    <= shreg_d;
            tx_q     <= (state == START) ? 1'b0 :
                        (state == DATA)  ? cur_byte[bit_idx] : 1'b1;
            busy_q   <= (state != IDLE) || busy_hold;
            ready_q  <= (count_d != DEPTH) && !hold_ready;
        end
    end
endmodule
